imem_stim_responder: RTL and testbench
======================================

Name: imem_stim_responder

Overview:
- Synthesizable, parametrised instruction-memory responder for the Sodor `Core` imem port in simulation benches.
- Generalises a single hardcoded instruction word into:
  - a DEPTH-entry loadable program table,
  - configurable response latency,
  - out-of-range detection,
  - a request counter.
- Sits between the bench and the core: its outputs drive `io_imem_resp_*`, and it observes `io_imem_req_*`.

Parameters:
- XLEN, 32, instruction/address width.
- DEPTH, 16, program table entries (power of 2, ≥2).
- LATENCY, 1, cycles from request to response, legal 0..4.
- BASE_ADDR, 32'h0, byte address of table entry 0.
- DEFAULT_INSTR, 32'h00000013, word returned for out-of-range or misaligned fetch (NOP).
- STALL_PERIOD, 4, used only under IMEM_STIM_STALL_EN; legal ≥2.

Ports:
- clock  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-low reset.
- load_en  in  1  — write load_data into table[load_idx] this cycle.
- load_idx  in  $clog2(DEPTH)  — table write index.
- load_data  in  XLEN  — table write data.
- req_valid  in  1  — from core `io_imem_req_valid`.
- req_addr  in  XLEN  — from core `io_imem_req_bits_addr`.
- resp_valid  out  1  — to core `io_imem_resp_valid`.
- resp_data  out  XLEN  — to core `io_imem_resp_bits_data`.
- req_count  out  32  — number of accepted requests.
- oob_err  out  1  — sticky flag: any out-of-range or misaligned fetch seen.

Behaviour:
- Reset (reset=0, asynchronous), all of these take their value immediately:
  - every table entry = DEFAULT_INSTR
  - pipeline valid bits = 0, resp_valid = 0, resp_data = 0
  - req_count = 0, oob_err = 0
- Address decode, combinational on req_addr:
  - off = req_addr − BASE_ADDR, computed modulo 2^XLEN.
  - idx = off[log2(DEPTH)+1:2].
  - in_range = (req_addr ≥ BASE_ADDR) && (off>>2 < DEPTH) && (off[1:0]==0).
  - fetched word = in_range ? table[idx] : DEFAULT_INSTR.
- Accept: a request is accepted in every cycle with req_valid=1. There is no backpressure.
  - req_count increments by 1 per accepted request and wraps at 2^32.
- Latency:
  - LATENCY=0: resp_valid=req_valid and resp_data=fetched word, both combinational. req_count and oob_err stay registered.
  - LATENCY=N≥1: an N-stage shift pipeline of {valid, data}. The stage is captured at accept time and presented exactly N rising edges later.
  - Stages whose valid bit is 0 carry data 0. resp_data = 0 whenever resp_valid = 0.
- Table write:
  - load_en writes table[load_idx] on the rising edge.
  - Load and fetch of the same index in the same cycle: the fetch returns the OLD value (read-before-write). The new value is visible from the next cycle.
- oob_err:
  - Set on the edge after an accepted request with in_range = 0.
  - Cleared only by reset.
- Back-to-back requests: one response per request, in order, with no bubbles inserted.
- Reset asserted mid-pipeline: all in-flight responses are discarded. No resp_valid appears after reset deasserts until a new request has been accepted.

Optional Feature:
- IMEM_STIM_STALL_EN defined:
  - A stall counter (0..STALL_PERIOD−1) advances on each accepted request.
  - The request accepted when the counter equals STALL_PERIOD−1 is dropped: its pipeline stage gets valid=0, data=0. The counter then wraps to 0.
  - req_count still counts the dropped request.
  - This exercises the core's fetch-stall path.
- Undefined: no stall counter exists, and every accepted request produces a response.

Test Plan:
- Reset low, then release; hold req_valid=0 for 5 cycles → resp_valid=0, resp_data=0, req_count=0, oob_err=0 throughout.
- Load table[0]=32'h00200313; request addr 0x0 continuously, LATENCY=1 → resp_valid=1 with data 32'h00200313 from the cycle after the first request onward; req_count=10 after 10 requests.
- LATENCY=3:
  - Load table[1]=32'h00100093 and table[2]=32'h002081b3.
  - Request addr 0x4 and then 0x8 on consecutive cycles.
  - → Responses 32'h00100093, then 32'h002081b3, exactly 3 and 4 cycles after the first request.
- Request addr 0x40 (DEPTH=16), then separately addr 0x2 → resp_data=32'h00000013 for each; oob_err=1 from the following cycle and it stays 1.
- Same-cycle load_en of idx 0 with 32'hdeadbeef while fetching addr 0 → response carries the old word; the next fetch of addr 0 returns 32'hdeadbeef.
- IMEM_STIM_STALL_EN with STALL_PERIOD=4, 8 continuous requests → responses for requests 4 and 8 have resp_valid=0; req_count=8. Assert reset during an in-flight response → resp_valid drops to 0 immediately.

Source files
------------

// File: rtl/imem_stim_responder.sv
// imem_stim_responder: loadable instruction-memory responder for the Sodor
// Core imem port. Serves words from a DEPTH-entry program table with a fixed
// LATENCY, flags out-of-range/misaligned fetches, and counts requests.
//
// Optional feature macro: IMEM_STIM_STALL_EN
//   When defined, every STALL_PERIOD-th accepted request is dropped (no
//   response) so the core's fetch-stall path gets exercised.
module imem_stim_responder #(
  parameter int              XLEN          = 32,
  parameter int              DEPTH         = 16,
  parameter int              LATENCY       = 1,
  parameter logic [XLEN-1:0] BASE_ADDR     = '0,
  parameter logic [XLEN-1:0] DEFAULT_INSTR = XLEN'(32'h00000013),
  parameter int              STALL_PERIOD  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [XLEN-1:0]          load_data,
  input  logic                     req_valid,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     resp_valid,
  output logic [XLEN-1:0]          resp_data,
  output logic [31:0]              req_count,
  output logic                     oob_err
);

  localparam int IDX_W = $clog2(DEPTH);

  // Elaboration-time parameter legality checks.
  if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
    $error("imem_stim_responder: LATENCY must be 0..4");
  end
  if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("imem_stim_responder: DEPTH must be a power of 2, >= 2");
  end
  if (STALL_PERIOD < 2) begin : g_bad_stall
    $error("imem_stim_responder: STALL_PERIOD must be >= 2");
  end

  logic [XLEN-1:0]  table_reg [DEPTH];
  logic [DEPTH-1:0] entry_we;
  logic [XLEN-1:0]  off;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [XLEN-1:0]  fetch_word;
  logic             drop;
  logic             stage_valid_in;
  logic [XLEN-1:0]  stage_data_in;
  logic [31:0]      req_count_reg;
  logic             oob_err_reg;

  // One-hot write enable per table entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign entry_we[gi] = load_en && (load_idx == IDX_W'(gi));
  end

  // Address decode: word index relative to BASE_ADDR; the upper-bits-zero
  // test is the same as (off >> 2) < DEPTH because DEPTH is a power of 2.
  always_comb begin
    off        = req_addr - BASE_ADDR;
    idx        = off[IDX_W+1:2];
    in_range   = (req_addr >= BASE_ADDR) &&
                 (off[XLEN-1:IDX_W+2] == '0) &&
                 (off[1:0] == 2'b00);
    // Reading the current table contents gives read-before-write for a
    // same-cycle load of the fetched index.
    fetch_word = in_range ? table_reg[idx] : DEFAULT_INSTR;
  end

  // Program table: resets to the default word, written by load_en.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= DEFAULT_INSTR;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) table_reg[i] <= load_data;
      end
    end
  end

`ifdef IMEM_STIM_STALL_EN
  localparam int STALL_W = $clog2(STALL_PERIOD);

  logic [STALL_W-1:0] stall_cnt_reg;
  logic [STALL_W-1:0] stall_cnt_next;

  // Stall counter advance; the request seen at the last count is dropped.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    drop           = 1'b0;
    if (req_valid) begin
      if (stall_cnt_reg == STALL_W'(STALL_PERIOD - 1)) begin
        drop           = 1'b1;
        stall_cnt_next = '0;
      end else begin
        stall_cnt_next = stall_cnt_reg + 1'b1;
      end
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cnt_reg <= '0;
    else        stall_cnt_reg <= stall_cnt_next;
  end
`else
  assign drop = 1'b0;
`endif

  // Response stage contents; data is forced to zero whenever valid is low.
  always_comb begin
    stage_valid_in = req_valid && !drop;
    stage_data_in  = stage_valid_in ? fetch_word : '0;
  end

  if (LATENCY == 0) begin : g_comb
    assign resp_valid = stage_valid_in;
    assign resp_data  = stage_data_in;
  end else begin : g_pipe
    logic [LATENCY-1:0] pipe_valid_reg;
    logic [XLEN-1:0]    pipe_data_reg [LATENCY];

    // Shift pipeline: stage 0 captures at accept, last stage drives the port.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < LATENCY; i++) begin
          pipe_valid_reg[i] <= 1'b0;
          pipe_data_reg[i]  <= '0;
        end
      end else begin
        pipe_valid_reg[0] <= stage_valid_in;
        pipe_data_reg[0]  <= stage_data_in;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_valid_reg[i] <= pipe_valid_reg[i-1];
          pipe_data_reg[i]  <= pipe_data_reg[i-1];
        end
      end
    end

    assign resp_valid = pipe_valid_reg[LATENCY-1];
    assign resp_data  = pipe_data_reg[LATENCY-1];
  end

  // Request counter (wraps naturally) and sticky out-of-range flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_count_reg <= '0;
      oob_err_reg   <= 1'b0;
    end else if (req_valid) begin
      req_count_reg <= req_count_reg + 32'd1;
      if (!in_range) oob_err_reg <= 1'b1;
    end
  end

  assign req_count = req_count_reg;
  assign oob_err   = oob_err_reg;

endmodule

// File: tb/tb_imem_stim_responder.sv
// Directed bench for imem_stim_responder: three instances (LATENCY 0, 1, 3)
// share one stimulus stream. Expected values are hand-computed constants.
module tb_imem_stim_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          load_en   = 1'b0;
  logic [IW-1:0] load_idx  = '0;
  logic [31:0]   load_data = '0;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr  = '0;

  logic        rv0, rv1, rv3;
  logic [31:0] rd0, rd1, rd3;
  logic [31:0] rc0, rc1, rc3;
  logic        oe0, oe1, oe3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  imem_stim_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(0)) d0 (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(rv0), .resp_data(rd0), .req_count(rc0), .oob_err(oe0));

  imem_stim_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(1)) d1 (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(rv1), .resp_data(rd1), .req_count(rc1), .oob_err(oe1));

  imem_stim_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(3)) d3 (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(rv3), .resp_data(rd3), .req_count(rc3), .oob_err(oe3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = data;
    cyc();
    load_en   = 1'b0;
  endtask

  initial begin
    // Asynchronous reset assertion, checked before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_rv0", rv0, 0);  check("rst_rd0", rd0, 0);
    check("rst_rv1", rv1, 0);  check("rst_rd1", rd1, 0);
    check("rst_rc1", rc1, 0);  check("rst_oe1", oe1, 0);
    check("rst_rv3", rv3, 0);  check("rst_rd3", rd3, 0);
    check("rst_rc3", rc3, 0);  check("rst_oe3", oe3, 0);
    cyc();
    cyc();
    reset = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_rv1", rv1, 0); check("idle_rd1", rd1, 0);
      check("idle_rc1", rc1, 0); check("idle_oe1", oe1, 0);
      check("idle_rv3", rv3, 0);
    end

`ifndef IMEM_STIM_STALL_EN
    // Continuous fetch of addr 0.
    load(0, 32'h00200313);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0;
      #1;
      check("cont_rv0", rv0, 1); check("cont_rd0", rd0, 32'h00200313);
      cyc();
      check("cont_rv1", rv1, 1); check("cont_rd1", rd1, 32'h00200313);
    end
    req_valid = 1'b0;
    check("cont_rc1", rc1, 10);
    check("cont_rc0", rc0, 10);
    #1;
    check("cont_idle_rv0", rv0, 0); check("cont_idle_rd0", rd0, 0);
    cyc();
    check("cont_drain_rv1", rv1, 0); check("cont_drain_rd1", rd1, 0);
    check("cont_tail_rv3", rv3, 1);
    cyc();
    check("cont_last_rv3", rv3, 1); check("cont_last_rd3", rd3, 32'h00200313);
    cyc();
    check("cont_drain_rv3", rv3, 0); check("cont_drain_rd3", rd3, 0);

    // LATENCY=3 back-to-back pair.
    load(1, 32'h00100093);
    load(2, 32'h002081b3);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    cyc();
    check("l3_c1_rv3", rv3, 0);
    check("l3_c1_rd1", rd1, 32'h00100093);
    req_addr = 32'h8;
    cyc();
    req_valid = 1'b0;
    check("l3_c2_rv3", rv3, 0);
    cyc();
    check("l3_c3_rv3", rv3, 1); check("l3_c3_rd3", rd3, 32'h00100093);
    cyc();
    check("l3_c4_rv3", rv3, 1); check("l3_c4_rd3", rd3, 32'h002081b3);
    cyc();
    check("l3_c5_rv3", rv3, 0); check("l3_c5_rd3", rd3, 0);
    check("l3_rc3", rc3, 12);

    // Same-cycle load and fetch of index 0: old word first.
    load_en   = 1'b1;
    load_idx  = 0;
    load_data = 32'hdeadbeef;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    #1;
    check("rbw_old_rd0", rd0, 32'h00200313);
    cyc();
    check("rbw_old_rd1", rd1, 32'h00200313);
    load_en = 1'b0;
    #1;
    check("rbw_new_rd0", rd0, 32'hdeadbeef);
    cyc();
    check("rbw_new_rd1", rd1, 32'hdeadbeef);
    req_valid = 1'b0;

    // Beyond the table end.
    req_valid = 1'b1;
    req_addr  = 32'h40;
    #1;
    check("oob40_rv0", rv0, 1); check("oob40_rd0", rd0, 32'h00000013);
    check("oob40_pre_oe0", oe0, 0);
    cyc();
    req_valid = 1'b0;
    check("oob40_oe1", oe1, 1); check("oob40_rd1", rd1, 32'h00000013);
    check("oob40_oe0", oe0, 1);
    cyc();
    cyc();
    check("oob40_sticky_oe1", oe1, 1); check("oob40_sticky_oe3", oe3, 1);
`else
    // Stall: every 4th accepted request gets no response.
    load(0, 32'h00200313);
    for (int i = 1; i <= 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0;
      #1;
      check("stall_rv0", rv0, (i % 4 != 0) ? 1 : 0);
      cyc();
      check("stall_rv1", rv1, (i % 4 != 0) ? 1 : 0);
      check("stall_rd1", rd1, (i % 4 != 0) ? 32'h00200313 : 32'h0);
    end
    req_valid = 1'b0;
    check("stall_rc1", rc1, 8);
    cyc();
    cyc();
    cyc();
`endif

    // Reset while responses are in flight.
    load(3, 32'h0000a0b7);
    req_valid = 1'b1;
    req_addr  = 32'hc;
    cyc();
    cyc();
    cyc();
    check("inflight_rv3", rv3, 1); check("inflight_rd3", rd3, 32'h0000a0b7);
    check("inflight_rv1", rv1, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_rv3", rv3, 0); check("midrst_rd3", rd3, 0);
    check("midrst_rv1", rv1, 0); check("midrst_rc1", rc1, 0);
    check("midrst_oe1", oe1, 0); check("midrst_rc0", rc0, 0);
    req_valid = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("postrst_rv3", rv3, 0); check("postrst_rv1", rv1, 0);
    end

    // Table back to default after reset; in-range fetch raises no error.
    req_valid = 1'b1;
    req_addr  = 32'hc;
    #1;
    check("tblrst_rd0", rd0, 32'h00000013); check("tblrst_oe0", oe0, 0);
    cyc();
    req_valid = 1'b0;
    check("tblrst_rd1", rd1, 32'h00000013); check("tblrst_oe1", oe1, 0);

    // Last in-range entry.
    load(15, 32'hcafef00d);
    req_valid = 1'b1;
    req_addr  = 32'h3c;
    #1;
    check("top_rd0", rd0, 32'hcafef00d);
    cyc();
    check("top_rd1", rd1, 32'hcafef00d); check("top_oe1", oe1, 0);

    // Misaligned fetch.
    req_addr = 32'h2;
    #1;
    check("mis_rv0", rv0, 1); check("mis_rd0", rd0, 32'h00000013);
    cyc();
    req_valid = 1'b0;
    check("mis_oe1", oe1, 1); check("mis_rd1", rd1, 32'h00000013);
    cyc();
    cyc();
    check("mis_sticky_oe1", oe1, 1);
    check("post_rc1", rc1, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
